// File: rtl/multdiv_seq_ctrl_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer and datapath.
package multdiv_seq_ctrl_pkg;

  localparam int MULTDIV_ITERS = 32;
  localparam int MULTDIV_CW    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply wins when both start pulses arrive together.
  function automatic logic div_select(input logic mult, input logic div);
    return div & ~mult;
  endfunction

endpackage

// File: rtl/multdiv_seq_ctrl_if.sv
// Pipeline <-> sequencer handshake: start pulses in, strobes and status out.
interface multdiv_seq_ctrl_if
  import multdiv_seq_ctrl_pkg::*;
#(
  parameter int CW = MULTDIV_CW
);

  logic          ctrl_mult;
  logic          ctrl_div;
  logic          div_by_zero;
  logic          load;
  logic          step;
  logic          is_div;
  logic          first_step;
  logic          last_step;
  logic [CW-1:0] count;
  logic          busy;
  logic          data_ready;
  logic          exception;

  modport master (
    output ctrl_mult, ctrl_div, div_by_zero,
    input  load, step, is_div, first_step, last_step, count, busy, data_ready, exception
  );

  modport slave (
    input  ctrl_mult, ctrl_div, div_by_zero,
    output load, step, is_div, first_step, last_step, count, busy, data_ready, exception
  );

endinterface

// File: rtl/multdiv_seq_ctrl_iter_counter.sv
// Iteration counter: clear dominates enable, wraps to zero after the terminal count.
module multdiv_seq_ctrl_iter_counter
  import multdiv_seq_ctrl_pkg::*;
#(
  parameter int ITERS = MULTDIV_ITERS,
  parameter int CW    = MULTDIV_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          term
);

  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  assign term = (count == LAST);

  // Explicit wrap keeps ITERS < 2**CW correct, not just the power-of-two case.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= term ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// IDLE/RUN/DONE sequencer driving load/step strobes for the multdiv datapath.
module multdiv_seq_ctrl
  import multdiv_seq_ctrl_pkg::*;
#(
  parameter int ITERS = MULTDIV_ITERS,
  parameter int CW    = MULTDIV_CW
) (
  input  logic                clock,
  input  logic                reset,
  multdiv_seq_ctrl_if.slave   bus
);

  state_e        state_q, state_d;
  logic          start;
  logic          dbz_start;
  logic          is_div_q;
  logic          exc_q;
  logic          run;
  logic          term;
  logic [CW-1:0] count;

  assign start     = bus.ctrl_mult | bus.ctrl_div;
  assign dbz_start = div_select(bus.ctrl_mult, bus.ctrl_div) & bus.div_by_zero;
  assign run       = (state_q == RUN);

  multdiv_seq_ctrl_iter_counter #(
    .ITERS (ITERS),
    .CW    (CW)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (start),
    .enable (run),
    .count  (count),
    .term   (term)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A start in any state, including mid-RUN, restarts the sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (term) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = dbz_start ? DONE : RUN;
  end

  // Exception is only ever set by a divide-by-zero start, which goes straight
  // to DONE; every other transition clears it, so it is 0 outside DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      exc_q <= dbz_start;
      if (start) is_div_q <= div_select(bus.ctrl_mult, bus.ctrl_div);
    end
  end

  assign bus.load       = start & reset;
  assign bus.step       = run;
  assign bus.busy       = run;
  assign bus.first_step = run & (count == '0);
  assign bus.last_step  = run & term;
  assign bus.count      = count;
  assign bus.is_div     = is_div_q;
  assign bus.data_ready = (state_q == DONE);
  assign bus.exception  = exc_q;

  a_exc_qual: assert property (@(posedge clock) disable iff (!reset)
    bus.exception |-> bus.data_ready);
  a_step_busy: assert property (@(posedge clock) disable iff (!reset)
    bus.step |-> bus.busy);
  a_done_idle: assert property (@(posedge clock) disable iff (!reset)
    bus.data_ready |-> !bus.busy);

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Directed bench for multdiv_seq_ctrl: latency, abort, divide-by-zero and reset behaviour.
module tb_multdiv_seq_ctrl;
  import multdiv_seq_ctrl_pkg::*;

  localparam int ITERS = MULTDIV_ITERS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  multdiv_seq_ctrl_if bus ();

  multdiv_seq_ctrl #(.ITERS(ITERS), .CW(MULTDIV_CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.ctrl_mult   = 1'b0;
    bus.ctrl_div    = 1'b0;
    bus.div_by_zero = 1'b0;
  endtask

  // Leaves the bench just after a rising edge, ready to drive the next cycle.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.ctrl_mult = 1'b1;
    @(negedge clock);
    tests++; if (bus.load !== 1'b0) begin fails++; $display("FAIL reset_load got %b want 0", bus.load); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL reset_step got %b want 0", bus.step); end
    tests++; if (bus.data_ready !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b want 0", bus.data_ready); end
    tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
    tests++; if (bus.is_div !== 1'b0) begin fails++; $display("FAIL reset_isdiv got %b want 0", bus.is_div); end
    tests++; if (bus.exception !== 1'b0) begin fails++; $display("FAIL reset_exc got %b want 0", bus.exception); end
    idle_inputs();
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    tests++; if (bus.busy !== 1'b0 || bus.count !== 5'd0) begin
      fails++; $display("FAIL idle_after_reset busy=%b count=%0d want 0/0", bus.busy, bus.count);
    end
    next_cycle();
  endtask

  // Full non-exception run started in cycle 0; checks every cycle up to one past DONE.
  task automatic test_full_op(input string nm, input logic m, input logic d, input logic z,
                              input logic exp_div);
    logic exp_step;
    bus.ctrl_mult = m; bus.ctrl_div = d; bus.div_by_zero = z;
    @(negedge clock);
    tests++; if (bus.load !== 1'b1) begin fails++; $display("FAIL %s load c0 got %b want 1", nm, bus.load); end
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= ITERS + 1; c++) begin
      @(negedge clock);
      exp_step = (c <= ITERS);
      tests++; if (bus.step !== exp_step) begin fails++; $display("FAIL %s step c%0d got %b want %b", nm, c, bus.step, exp_step); end
      tests++; if (bus.busy !== exp_step) begin fails++; $display("FAIL %s busy c%0d got %b want %b", nm, c, bus.busy, exp_step); end
      tests++; if (bus.data_ready !== !exp_step) begin fails++; $display("FAIL %s rdy c%0d got %b want %b", nm, c, bus.data_ready, !exp_step); end
      tests++; if (bus.is_div !== exp_div) begin fails++; $display("FAIL %s isdiv c%0d got %b want %b", nm, c, bus.is_div, exp_div); end
      tests++; if (bus.exception !== 1'b0) begin fails++; $display("FAIL %s exc c%0d got %b want 0", nm, c, bus.exception); end
      if (exp_step) begin
        tests++; if (bus.count !== 5'(c - 1)) begin fails++; $display("FAIL %s count c%0d got %0d want %0d", nm, c, bus.count, c - 1); end
        tests++; if (bus.first_step !== (c == 1)) begin fails++; $display("FAIL %s first c%0d got %b", nm, c, bus.first_step); end
        tests++; if (bus.last_step !== (c == ITERS)) begin fails++; $display("FAIL %s last c%0d got %b", nm, c, bus.last_step); end
      end
      next_cycle();
    end
    @(negedge clock);
    tests++; if (bus.data_ready !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 5'd0) begin
      fails++; $display("FAIL %s post_idle rdy=%b busy=%b count=%0d want 0/0/0", nm, bus.data_ready, bus.busy, bus.count);
    end
    next_cycle();
  endtask

  task automatic test_mult();
    test_full_op("mult", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    test_full_op("div", 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_both();
    test_full_op("both_dbz", 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_div_by_zero();
    bus.ctrl_div = 1'b1; bus.div_by_zero = 1'b1;
    @(negedge clock);
    tests++; if (bus.load !== 1'b1) begin fails++; $display("FAIL dbz load c0 got %b want 1", bus.load); end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    tests++; if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL dbz rdy c1 got %b want 1", bus.data_ready); end
    tests++; if (bus.exception !== 1'b1) begin fails++; $display("FAIL dbz exc c1 got %b want 1", bus.exception); end
    tests++; if (bus.step !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL dbz step c1 step=%b busy=%b want 0/0", bus.step, bus.busy); end
    tests++; if (bus.is_div !== 1'b1) begin fails++; $display("FAIL dbz isdiv c1 got %b want 1", bus.is_div); end
    next_cycle();
    @(negedge clock);
    tests++; if (bus.data_ready !== 1'b0 || bus.exception !== 1'b0 || bus.step !== 1'b0) begin
      fails++; $display("FAIL dbz c2 rdy=%b exc=%b step=%b want 0/0/0", bus.data_ready, bus.exception, bus.step);
    end
    next_cycle();
  endtask

  task automatic test_abort();
    bus.ctrl_mult = 1'b1;
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 44; c++) begin
      if (c == 10) bus.ctrl_div = 1'b1;
      @(negedge clock);
      tests++; if (bus.data_ready !== (c == 43)) begin fails++; $display("FAIL abort rdy c%0d got %b want %b", c, bus.data_ready, (c == 43)); end
      if (c == 10) begin
        tests++; if (bus.count !== 5'd9 || bus.load !== 1'b1) begin fails++; $display("FAIL abort c10 count=%0d load=%b want 9/1", bus.count, bus.load); end
      end
      if (c == 11) begin
        tests++; if (bus.count !== 5'd0 || bus.is_div !== 1'b1 || bus.step !== 1'b1) begin
          fails++; $display("FAIL abort c11 count=%0d isdiv=%b step=%b want 0/1/1", bus.count, bus.is_div, bus.step);
        end
      end
      next_cycle();
      if (c == 10) idle_inputs();
    end
  endtask

  task automatic test_async_reset();
    int seen;
    bus.ctrl_mult = 1'b1;
    next_cycle();
    idle_inputs();
    repeat (17) next_cycle();
    @(negedge clock);
    tests++; if (bus.count !== 5'd17) begin fails++; $display("FAIL arst pre count got %0d want 17", bus.count); end
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.step !== 1'b0 || bus.count !== 5'd0) begin
      fails++; $display("FAIL arst async busy=%b step=%b count=%0d want 0/0/0", bus.busy, bus.step, bus.count);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.data_ready === 1'b1 || bus.busy === 1'b1) seen++;
      next_cycle();
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL arst no_resume activity cycles got %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    bus.ctrl_mult = 1'b1;
    next_cycle();
    idle_inputs();
    repeat (ITERS) next_cycle();
    bus.ctrl_mult = 1'b1;
    @(negedge clock);
    tests++; if (bus.data_ready !== 1'b1 || bus.load !== 1'b1) begin
      fails++; $display("FAIL b2b done rdy=%b load=%b want 1/1", bus.data_ready, bus.load);
    end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    tests++; if (bus.step !== 1'b1 || bus.count !== 5'd0 || bus.first_step !== 1'b1) begin
      fails++; $display("FAIL b2b restart step=%b count=%0d first=%b want 1/0/1", bus.step, bus.count, bus.first_step);
    end
    tests++; if (bus.data_ready !== 1'b0) begin fails++; $display("FAIL b2b rdy after restart got %b want 0", bus.data_ready); end
    repeat (ITERS - 1) next_cycle();
    @(negedge clock);
    tests++; if (bus.last_step !== 1'b1) begin fails++; $display("FAIL b2b last got %b want 1", bus.last_step); end
    next_cycle();
    @(negedge clock);
    tests++; if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL b2b second rdy got %b want 1", bus.data_ready); end
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_abort();
    test_both();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
